proc_dpath_imm_gen_pipe: RTL and testbench

- Pipelined, multi-lane successor to the datapath immediate generator.
- Decodes NLANES instructions per transaction into XLEN-bit immediates.
- Adds a val/rdy handshake, a 2-entry output buffer, two extra immediate formats, and illegal-type error reporting in place of simulation halt.
- Sits between decode and the operand-select stage for superscalar/XLEN-64 datapath variants.

---
 rtl/proc_imm_pkg.sv | 25 ++
 rtl/proc_imm_decode_lane.sv | 42 ++++
 rtl/proc_dpath_imm_gen_pipe.sv | 126 ++++++++++++
 tb/tb_proc_dpath_imm_gen_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_imm_pkg.sv
// Shared types and constants for the pipelined multi-lane immediate generator.
package proc_imm_pkg;

    localparam int INST_W   = 32;
    localparam int XLEN_MAX = 64;

    // Immediate format selector carried alongside each instruction lane.
    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_U   = 3'd3,
        IMM_J   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_IU  = 3'd6,
        IMM_ILL = 3'd7
    } imm_type_t;

    // One decoded lane: immediate plus illegal-type flag.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic                err;
    } imm_lane_t;

endpackage

// File: rtl/proc_imm_decode_lane.sv
// Purely combinational single-lane immediate decoder.
module proc_imm_decode_lane
    import proc_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        imm_type,
    input  logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   imm,
    output logic              err
);

    logic signed [INST_W-1:0] val_p0;
    logic                     unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^inst[6:0];

    // Widen a 32-bit signed immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext_xlen(input logic signed [INST_W-1:0] v);
        sext_xlen = XLEN'(v);
    endfunction

    // Assemble the 32-bit immediate per format, then widen; zero-extended
    // formats keep bit 31 clear so the widening leaves the top bits zero.
    always_comb begin
        val_p0 = '0;
        err    = 1'b0;
        case (imm_type_t'(imm_type))
            IMM_I:   val_p0 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   val_p0 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   val_p0 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   val_p0 = {inst[31:12], 12'b0};
            IMM_J:   val_p0 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:   val_p0 = {27'b0, inst[19:15]};
            IMM_IU:  val_p0 = {20'b0, inst[31:20]};
            default: err    = 1'b1;
        endcase
        imm = sext_xlen(val_p0);
    end

endmodule

// File: rtl/proc_dpath_imm_gen_pipe.sv
// Multi-lane immediate generator with val/rdy handshake, 2-entry output
// buffer and illegal-type error accounting.
module proc_dpath_imm_gen_pipe
    import proc_imm_pkg::*;
#(
    parameter int NLANES    = 2,
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [3*NLANES-1:0]      in_imm_type,
    input  logic [INST_W*NLANES-1:0] in_inst,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [XLEN*NLANES-1:0]   out_imm,
    output logic [NLANES-1:0]        out_err,
    input  logic                     err_clr,
    output logic                     err_sticky,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int INC_W = $clog2(NLANES + 1);
    localparam int SUM_W = ERR_CNT_W + INC_W;

    // Number of illegal lanes in one transaction.
    function automatic logic [INC_W-1:0] count_err(input logic [NLANES-1:0] e);
        count_err = '0;
        for (int k = 0; k < NLANES; k++) begin
            count_err = count_err + INC_W'(e[k]);
        end
    endfunction

    // Add to the error counter, clamping at its maximum value.
    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] base,
                                                     input logic [INC_W-1:0]     inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > SUM_W'({ERR_CNT_W{1'b1}})) begin
            sat_add = '1;
        end else begin
            sat_add = sum[ERR_CNT_W-1:0];
        end
    endfunction

    // ---- stage p0: combinational decode at enqueue ----
    logic [XLEN*NLANES-1:0] dec_imm_p0;
    logic [NLANES-1:0]      dec_err_p0;
    logic [INC_W-1:0]       inc_p0;
    logic                   enq_p0;
    logic                   deq_p1;

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        proc_imm_decode_lane #(
            .XLEN (XLEN)
        ) u_dec (
            .imm_type (in_imm_type[3*k +: 3]),
            .inst     (in_inst[INST_W*k +: INST_W]),
            .imm      (dec_imm_p0[XLEN*k +: XLEN]),
            .err      (dec_err_p0[k])
        );
    end

    assign inc_p0 = count_err(dec_err_p0);

    // ---- stage p1: 2-entry output buffer ----
    logic [XLEN*NLANES-1:0] mem_imm_p1 [2];
    logic [NLANES-1:0]      mem_err_p1 [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             occ;
    logic                   vld_p1;

    assign in_rdy = (occ != 2'd2);
    assign vld_p1 = (occ != 2'd0);
    assign enq_p0 = in_val && in_rdy;
    assign deq_p1 = vld_p1 && out_rdy;

    // Outputs come only from the buffer head; an empty buffer presents zeros.
    assign out_val = vld_p1;
    assign out_imm = vld_p1 ? mem_imm_p1[rd_ptr] : '0;
    assign out_err = vld_p1 ? mem_err_p1[rd_ptr] : '0;

    // Buffer pointers and occupancy; reset discards any buffered entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (enq_p0) wr_ptr <= ~wr_ptr;
            if (deq_p1) rd_ptr <= ~rd_ptr;
            case ({enq_p0, deq_p1})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Buffer payload; gated at the output, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq_p0) begin
            mem_imm_p1[wr_ptr] <= dec_imm_p0;
            mem_err_p1[wr_ptr] <= dec_err_p0;
        end
    end

    // Illegal-type accounting on accepted transactions; a clear coinciding
    // with an enqueue restarts the count from that transaction's errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (err_clr) begin
            err_count  <= enq_p0 ? sat_add('0, inc_p0) : '0;
            err_sticky <= enq_p0 && (inc_p0 != '0);
        end else if (enq_p0 && (inc_p0 != '0)) begin
            err_count  <= sat_add(err_count, inc_p0);
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_dpath_imm_gen_pipe.sv
// Bench: two instances (XLEN=64/ERR_CNT_W=2 and XLEN=32/ERR_CNT_W=8) share
// one stimulus stream and are checked against a queue-based reference model.
module tb_proc_dpath_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        out_rdy;
    logic        err_clr;
    logic [5:0]  in_imm_type;
    logic [63:0] in_inst;

    logic         a_in_rdy, a_out_val, a_err_sticky;
    logic [127:0] a_out_imm;
    logic [1:0]   a_out_err;
    logic [1:0]   a_err_count;

    logic         b_in_rdy, b_out_val, b_err_sticky;
    logic [63:0]  b_out_imm;
    logic [1:0]   b_out_err;
    logic [7:0]   b_err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    proc_dpath_imm_gen_pipe #(.NLANES(2), .XLEN(64), .ERR_CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(a_in_rdy),
        .in_imm_type(in_imm_type), .in_inst(in_inst), .out_val(a_out_val),
        .out_rdy(out_rdy), .out_imm(a_out_imm), .out_err(a_out_err),
        .err_clr(err_clr), .err_sticky(a_err_sticky), .err_count(a_err_count)
    );

    proc_dpath_imm_gen_pipe #(.NLANES(2), .XLEN(32), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(b_in_rdy),
        .in_imm_type(in_imm_type), .in_inst(in_inst), .out_val(b_out_val),
        .out_rdy(out_rdy), .out_imm(b_out_imm), .out_err(b_out_err),
        .err_clr(err_clr), .err_sticky(b_err_sticky), .err_count(b_err_count)
    );

    typedef struct packed {
        logic [63:0] imm1;
        logic [63:0] imm0;
        logic [1:0]  err;
    } txn_t;

    txn_t q[$];
    int   m_cnt_a  = 0;
    int   m_cnt_b  = 0;
    bit   m_sticky = 1'b0;

    // Reference immediate value, built from field arithmetic on integers.
    function automatic logic [63:0] ref_imm(input int unsigned t, input logic [31:0] inst);
        longint x;
        longint v;
        x = longint'({32'd0, inst});
        case (t)
            0: begin v = (x >> 20) & 'hFFF; if (inst[31]) v -= 4096; end
            1: begin v = (((x >> 25) & 'h7F) << 5) | ((x >> 7) & 'h1F); if (inst[31]) v -= 4096; end
            2: begin
                v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
                  | (((x >> 25) & 'h3F) << 5) | (((x >> 8) & 'hF) << 1);
                if (inst[31]) v -= 8192;
            end
            3: begin v = x & 'hFFFFF000; if (inst[31]) v -= 64'h1_0000_0000; end
            4: begin
                v = (((x >> 31) & 1) << 20) | (((x >> 12) & 'hFF) << 12)
                  | (((x >> 20) & 1) << 11) | (((x >> 21) & 'h3FF) << 1);
                if (inst[31]) v -= 64'h20_0000;
            end
            5: v = (x >> 15) & 'h1F;
            6: v = (x >> 20) & 'hFFF;
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int unsigned t0, input logic [31:0] i0,
                         input int unsigned t1, input logic [31:0] i1);
        in_val      = v;
        in_imm_type = {t1[2:0], t0[2:0]};
        in_inst     = {i1, i0};
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the
    // model across the rising edge. Returns at posedge + 1.
    task automatic cycle();
        txn_t h;
        bit   enq, deq;
        int   inc;
        @(negedge clk);
        chk("a_out_val", a_out_val, q.size() != 0);
        chk("b_out_val", b_out_val, q.size() != 0);
        chk("a_in_rdy", a_in_rdy, q.size() < 2);
        chk("b_in_rdy", b_in_rdy, q.size() < 2);
        if (q.size() != 0) begin
            h = q[0];
            chk("a_out_imm", a_out_imm, {h.imm1, h.imm0});
            chk("b_out_imm", b_out_imm, {h.imm1[31:0], h.imm0[31:0]});
            chk("a_out_err", a_out_err, h.err);
            chk("b_out_err", b_out_err, h.err);
        end
        chk("a_err_count", a_err_count, m_cnt_a);
        chk("b_err_count", b_err_count, m_cnt_b);
        chk("a_err_sticky", a_err_sticky, m_sticky);
        chk("b_err_sticky", b_err_sticky, m_sticky);
        enq = in_val && (q.size() < 2);
        deq = (q.size() != 0) && out_rdy;
        @(posedge clk);
        if (deq) h = q.pop_front();
        inc = 0;
        if (enq) begin
            h.imm0 = ref_imm(in_imm_type[2:0], in_inst[31:0]);
            h.imm1 = ref_imm(in_imm_type[5:3], in_inst[63:32]);
            h.err  = {in_imm_type[5:3] == 3'd7, in_imm_type[2:0] == 3'd7};
            inc    = int'(h.err[0]) + int'(h.err[1]);
            q.push_back(h);
        end
        if (err_clr) begin
            m_cnt_a  = (inc > 3) ? 3 : inc;
            m_cnt_b  = inc;
            m_sticky = (inc != 0);
        end else if (inc != 0) begin
            m_cnt_a  = (m_cnt_a + inc > 3) ? 3 : m_cnt_a + inc;
            m_cnt_b  = (m_cnt_b + inc > 255) ? 255 : m_cnt_b + inc;
            m_sticky = 1'b1;
        end
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_a_out_val", a_out_val, 1'b0);
        chk("rst_a_in_rdy", a_in_rdy, 1'b1);
        chk("rst_a_out_imm", a_out_imm, 128'h0);
        chk("rst_b_out_imm", b_out_imm, 128'h0);
        chk("rst_a_out_err", a_out_err, 2'b00);
        chk("rst_a_err_count", a_err_count, 2'd0);
        chk("rst_a_err_sticky", a_err_sticky, 1'b0);

        // Single I-type transaction.
        drive(1, 0, 32'hFFF00093, 0, 32'h00500113);
        cycle();
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("i_a_out_val", a_out_val, 1'b1);
        chk("i_a_imm", a_out_imm, {64'h5, 64'hFFFF_FFFF_FFFF_FFFF});
        chk("i_b_imm", b_out_imm, {32'h5, 32'hFFFF_FFFF});
        chk("i_a_err", a_out_err, 2'b00);
        out_rdy = 1'b1;
        cycle();

        // Remaining formats, directed values. For the B case inst[7]=1 sets
        // imm[11], so 0xFE000EE3 encodes -4.
        drive(1, 3, 32'h800002B7, 2, 32'hFE000EE3);
        cycle();
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("ub_a_imm", a_out_imm, {64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000});
        cycle();
        drive(1, 4, 32'h0080006F, 5, 32'h000FD073);
        cycle();
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("jz_a_imm", a_out_imm, {64'h1F, 64'h8});
        cycle();
        drive(1, 6, 32'hFFF00093, 1, 32'hFE112E23);
        cycle();
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("ius_a_imm", a_out_imm, {64'hFFFF_FFFF_FFFF_FFFC, 64'hFFF});
        chk("ius_b_imm", b_out_imm, {32'hFFFF_FFFC, 32'hFFF});
        cycle();

        // Backpressure: only two transactions fit while the consumer stalls.
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom_range(0, 6), $urandom, $urandom_range(0, 6), $urandom);
            cycle();
        end
        chk("bp_a_in_rdy", a_in_rdy, 1'b0);
        chk("bp_a_out_val", a_out_val, 1'b1);
        drive(0, 0, 32'h0, 0, 32'h0);
        out_rdy = 1'b1;
        repeat (3) cycle();

        // Streaming: ten back-to-back transactions with the consumer ready.
        for (int i = 0; i < 10; i++) begin
            drive(1, $urandom_range(0, 6), $urandom, $urandom_range(0, 6), $urandom);
            cycle();
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        cycle();

        // Random handshakes, formats and occasional clears.
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 7), $urandom);
            out_rdy = 1'($urandom_range(0, 1));
            err_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Error saturation with a 2-bit counter.
        drive(0, 0, 32'h0, 0, 32'h0);
        out_rdy = 1'b1;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, $urandom, 7, $urandom);
            cycle();
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("sat_a_count", a_err_count, 2'd3);
        chk("sat_b_count", b_err_count, 8'd6);
        chk("sat_a_sticky", a_err_sticky, 1'b1);
        chk("sat_a_out_err", a_out_err, 2'b11);
        cycle();
        err_clr = 1'b1;
        drive(1, 7, $urandom, 0, 32'h00500113);
        cycle();
        err_clr = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("clr_a_count", a_err_count, 2'd1);
        chk("clr_b_count", b_err_count, 8'd1);
        chk("clr_a_sticky", a_err_sticky, 1'b1);
        cycle();

        // Asynchronous reset with a full buffer and a stalled consumer.
        out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom_range(0, 6), $urandom, $urandom_range(0, 6), $urandom);
            cycle();
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("pre_rst_a_in_rdy", a_in_rdy, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_a_out_val", a_out_val, 1'b0);
        chk("arst_b_out_val", b_out_val, 1'b0);
        q.delete();
        m_cnt_a  = 0;
        m_cnt_b  = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_a_in_rdy", a_in_rdy, 1'b1);
        chk("post_rst_a_out_val", a_out_val, 1'b0);
        out_rdy = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
